// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader.
// Assembles little-endian words, then serves fetches.
module imem_loader #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ld_valid,
   input  logic [7:0]                  ld_data,
   input  logic                        ld_last,
   output logic                        ld_ready,
   input  logic [31:0]                 pc,
   output logic [31:0]                 instruction,
   output logic                        core_rst,
   output logic [$clog2(DEPTH_WORDS):0] loaded_words,
   output logic                        err_overflow,
   output logic                        err_misaligned
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH_WORDS);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [31:0] NOP = 32'h00000013;

   typedef enum logic [1:0] {
      S_LOAD,
      S_RUN,
      S_ERROR
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [AW:0] idx_q, idx_d;
   logic [31:0] asm_q, asm_d;
   logic        ovf_q, ovf_d;
   logic        mis_q, mis_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic          accept;
   logic          we;
   logic [31:0]   byte_sh;
   logic [31:0]   wdata;
   logic [AW-1:0] rd_idx;
   logic          in_range;
   logic          hit;

   // Handshake and byte placement into the assembly word.
   always_comb begin
      ld_ready = (state_q == S_LOAD) && !rst;
      accept   = ld_valid && ld_ready;
      byte_sh  = 32'(ld_data) << {cnt_q, 3'b000};
      // asm_q is cleared after every write, so unfilled
      // upper bytes of a short final word are already zero.
      wdata    = asm_q | byte_sh;
   end

   // State register and all sequential control state.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      mis_q   <= mis_d;
   end

   // Next-state logic: load sequencing, overflow and misalign flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      ovf_d   = ovf_q;
      mis_d   = mis_q;
      we      = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            if (accept) begin
               if (idx_q == FULL) begin
                  state_d = S_ERROR;
                  ovf_d   = 1'b1;
               end else if (cnt_q == 2'd3 || ld_last) begin
                  we    = 1'b1;
                  idx_d = idx_q + ONE;
                  cnt_d = 2'd0;
                  asm_d = 32'd0;
                  if (ld_last) state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + 2'd1;
                  asm_d = wdata;
               end
            end
         end
         S_RUN: begin
            if (pc[1:0] != 2'b00) mis_d = 1'b1;
         end
         default: ;
      endcase
      if (rst) begin
         state_d = S_LOAD;
         cnt_d   = 2'd0;
         idx_d   = '0;
         asm_d   = 32'd0;
         ovf_d   = 1'b0;
         mis_d   = 1'b0;
         we      = 1'b0;
      end
   end

   // Program storage; never cleared, stale words hidden by the count.
   always_ff @(posedge clk) begin
      if (we) mem[idx_q[AW-1:0]] <= wdata;
   end

   // Fetch path: only loaded, aligned, in-range words in RUN.
   always_comb begin
      rd_idx      = pc[AW+1:2];
      in_range    = (pc[31:AW+2] == '0);
      hit         = (state_q == S_RUN) && !rst &&
                    (pc[1:0] == 2'b00) && in_range &&
                    ({1'b0, rd_idx} < idx_q);
      instruction = hit ? mem[rd_idx] : NOP;
   end

   // Status outputs decoded from registered state.
   always_comb begin
      core_rst       = rst || (state_q != S_RUN);
      loaded_words   = idx_q;
      err_overflow   = ovf_q;
      err_misaligned = mis_q;
   end

endmodule
